// File: rtl/arbitro_rr_param.sv
// ============================================================================
// Module   : arbitro_rr_param
// Purpose  : N_IN -> N_OUT FIFO-bank arbiter with round-robin or fixed
//            priority, per-destination backpressure, burst hold and
//            per-output transfer counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr_param #(
    parameter int N_IN      = 4,
    parameter int N_OUT     = 4,
    parameter int DEST_W    = 2,
    parameter int SEL_W     = 2,
    parameter int PRIO_MODE = 0,
    parameter int BURST_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_IN-1:0]         empty,
    input  logic [N_IN*DEST_W-1:0]  destino,
    input  logic [N_OUT-1:0]        full,
    input  logic                    cnt_clr,
    output logic [N_IN-1:0]         pop,
    output logic [N_OUT-1:0]        push,
    output logic [SEL_W-1:0]        demux,
    output logic [DEST_W-1:0]       dest_sel,
    output logic                    busy,
    output logic [N_OUT*CNT_W-1:0]  cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic [SEL_W-1:0]    r_owner;
    logic [3:0]          r_burst_cnt;

    logic [DEST_W-1:0]   w_dest [N_IN];
    logic [N_IN-1:0]     w_elig;
    logic                w_owner_keep;
    logic                w_found;
    logic [SEL_W-1:0]    w_grant;
    logic [SEL_W-1:0]    w_idx;
    logic [SEL_W-1:0]    w_grant_nxt;
    logic [SEL_W-1:0]    w_owner_nxt;
    logic                w_xfer;

    // An out-of-range destination is treated as blocked rather than indexing past full.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_dest[i] = destino[i*DEST_W +: DEST_W];
            w_elig[i] = enable && !empty[i] && (int'(w_dest[i]) < N_OUT) && !full[w_dest[i]];
        end
    end

    // Scans run from last to first candidate so the earliest eligible one is assigned last.
    always_comb begin
        w_owner_keep = (r_state == ST_BURST) && w_elig[r_owner];
        w_found      = 1'b0;
        w_grant      = '0;
        w_idx        = '0;
        if (w_owner_keep) begin
            w_found = 1'b1;
            w_grant = r_owner;
        end else if (PRIO_MODE == 1) begin
            for (int i = N_IN-1; i >= 0; i--) begin
                w_idx = SEL_W'(i);
                if (w_elig[w_idx]) begin
                    w_found = 1'b1;
                    w_grant = w_idx;
                end
            end
        end else begin
            for (int k = N_IN-1; k >= 0; k--) begin
                w_idx = SEL_W'((int'(r_rr_ptr) + k) % N_IN);
                if (w_elig[w_idx]) begin
                    w_found = 1'b1;
                    w_grant = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_grant_nxt = (w_grant == SEL_W'(N_IN-1)) ? '0 : w_grant + 1'b1;
        w_owner_nxt = (r_owner == SEL_W'(N_IN-1)) ? '0 : r_owner + 1'b1;
    end

    // Reset gates the strobes directly so they drop without waiting for the flops.
    always_comb begin
        w_xfer   = w_found && !reset;
        pop      = '0;
        push     = '0;
        demux    = '0;
        dest_sel = '0;
        busy     = 1'b0;
        if (w_xfer) begin
            pop      = {{(N_IN-1){1'b0}}, 1'b1} << w_grant;
            push     = {{(N_OUT-1){1'b0}}, 1'b1} << w_dest[w_grant];
            demux    = w_grant;
            dest_sel = w_dest[w_grant];
            busy     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        if (BURST_LEN > 1) begin
                            r_state     <= ST_BURST;
                            r_owner     <= w_grant;
                            r_burst_cnt <= 4'd1;
                        end else begin
                            r_rr_ptr <= w_grant_nxt;
                        end
                    end
                end
                ST_BURST: begin
                    if (enable) begin
                        if (w_owner_keep &&
                            (({1'b0, r_burst_cnt} + 5'd1) < 5'(BURST_LEN))) begin
                            r_burst_cnt <= r_burst_cnt + 4'd1;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_rr_ptr    <= w_owner_nxt;
                            r_burst_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar j = 0; j < N_OUT; j++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (cnt_clr) begin
                    r_cnt <= '0;
                end else if (push[j]) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign cnt[j*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_arbitro_rr_param.sv
// ============================================================================
// Module   : tb_arbitro_rr_param
// Purpose  : Scenario bench for arbitro_rr_param (RR, fixed-priority, burst).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_rr_param;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        cnt_clr;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [7:0]  destino;

    logic [3:0]  a_pop, a_push, b_pop, b_push, c_pop, c_push;
    logic [1:0]  a_demux, a_dest, b_demux, b_dest, c_demux, c_dest;
    logic        a_busy, b_busy, c_busy;
    logic [15:0] a_cnt;
    logic [31:0] b_cnt, c_cnt;
    logic [12:0] a_vec, b_vec, c_vec;

    logic [12:0] sb[$];
    logic [12:0] e;
    int checks = 0;
    int errors = 0;

    assign a_vec = {a_pop, a_push, a_demux, a_dest, a_busy};
    assign b_vec = {b_pop, b_push, b_demux, b_dest, b_busy};
    assign c_vec = {c_pop, c_push, c_demux, c_dest, c_busy};

    arbitro_rr_param #(.PRIO_MODE(0), .BURST_LEN(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .empty(empty), .destino(destino),
        .full(full), .cnt_clr(cnt_clr), .pop(a_pop), .push(a_push), .demux(a_demux),
        .dest_sel(a_dest), .busy(a_busy), .cnt(a_cnt));

    arbitro_rr_param #(.PRIO_MODE(0), .BURST_LEN(3), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .empty(empty), .destino(destino),
        .full(full), .cnt_clr(cnt_clr), .pop(b_pop), .push(b_push), .demux(b_demux),
        .dest_sel(b_dest), .busy(b_busy), .cnt(b_cnt));

    arbitro_rr_param #(.PRIO_MODE(1), .BURST_LEN(1), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .empty(empty), .destino(destino),
        .full(full), .cnt_clr(cnt_clr), .pop(c_pop), .push(c_push), .demux(c_demux),
        .dest_sel(c_dest), .busy(c_busy), .cnt(c_cnt));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    // Expected {pop, push, demux, dest_sel, busy} for input g sending to output d.
    function automatic logic [12:0] ex(input int g, input int d);
        return {4'(1 << g), 4'(1 << d), 2'(g), 2'(d), 1'b1};
    endfunction

    task automatic apply_reset();
        reset   = 1'b1;
        cnt_clr = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1; empty = 4'b0000; full = 4'b0000; cnt_clr = 1'b0;
        destino = 8'b11_10_01_00;
        reset = 1'b1;
        @(posedge clk); #3;
        sb.push_back(13'd0);
        sb.push_back(13'd0);
        checks++; e = sb.pop_front();
        if (a_vec !== e) begin errors++; $display("FAIL reset_out_a: got %h expected %h", a_vec, e); end
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL reset_out_b: got %h expected %h", b_vec, e); end
        checks++;
        if (a_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", a_cnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        sb.push_back(ex(0, 0));
        checks++; e = sb.pop_front();
        if (a_vec !== e) begin errors++; $display("FAIL reset_release_grant: got %h expected %h", a_vec, e); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        enable = 1'b1; empty = 4'b0000; full = 4'b0000; destino = 8'b11_10_01_00;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(ex(k % 4, k % 4));
            sb.push_back(ex(0, 0));
            #2;
            checks++; e = sb.pop_front();
            if (a_vec !== e) begin errors++; $display("FAIL rr_step%0d: got %h expected %h", k, a_vec, e); end
            checks++; e = sb.pop_front();
            if (c_vec !== e) begin errors++; $display("FAIL prio_step%0d: got %h expected %h", k, c_vec, e); end
            @(posedge clk); #1;
        end
        checks++;
        if (a_cnt !== {4'd1, 4'd1, 4'd1, 4'd2})
            begin errors++; $display("FAIL rr_counts: got %h expected 1112", a_cnt); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        enable = 1'b1; full = 4'b0010; empty = 4'b1010;
        destino = {2'd3, 2'd0, 2'd2, 2'd1};
        for (int k = 0; k < 4; k++) begin
            sb.push_back(ex(2, 0));
            sb.push_back(ex(2, 0));
            #2;
            checks++; e = sb.pop_front();
            if (a_vec !== e) begin errors++; $display("FAIL bp_blocked%0d: got %h expected %h", k, a_vec, e); end
            checks++; e = sb.pop_front();
            if (c_vec !== e) begin errors++; $display("FAIL bp_prio%0d: got %h expected %h", k, c_vec, e); end
            @(posedge clk); #1;
        end
        full = 4'b0000;
        sb.push_back(ex(0, 1));
        sb.push_back(ex(0, 1));
        #2;
        checks++; e = sb.pop_front();
        if (a_vec !== e) begin errors++; $display("FAIL bp_released: got %h expected %h", a_vec, e); end
        checks++; e = sb.pop_front();
        if (c_vec !== e) begin errors++; $display("FAIL bp_released_prio: got %h expected %h", c_vec, e); end
    endtask

    task automatic test_burst();
        int seq [7] = '{0, 0, 0, 1, 1, 1, 0};
        apply_reset();
        enable = 1'b1; empty = 4'b1100; full = 4'b0000; destino = 8'b11_10_01_00;
        for (int k = 0; k < 7; k++) begin
            sb.push_back(ex(seq[k], seq[k]));
            #2;
            checks++; e = sb.pop_front();
            if (b_vec !== e) begin errors++; $display("FAIL burst_step%0d: got %h expected %h", k, b_vec, e); end
            @(posedge clk); #1;
        end
        apply_reset();
        sb.push_back(ex(0, 0));
        #2;
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL burst_first: got %h expected %h", b_vec, e); end
        @(posedge clk); #1;
        enable = 1'b0;
        sb.push_back(13'd0);
        #2;
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL burst_enable_hold: got %h expected %h", b_vec, e); end
        @(posedge clk); #1;
        enable = 1'b1;
        sb.push_back(ex(0, 0));
        #2;
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL burst_resume: got %h expected %h", b_vec, e); end
        @(posedge clk); #1;
        empty = 4'b1101;
        sb.push_back(ex(1, 1));
        #2;
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL burst_owner_empty: got %h expected %h", b_vec, e); end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        enable = 1'b1; empty = 4'b1011; full = 4'b0000; destino = {2'd0, 2'd2, 2'd0, 2'd0};
        for (int k = 0; k < 17; k++) begin
            sb.push_back(ex(2, 2));
            #2;
            checks++; e = sb.pop_front();
            if (a_vec !== e) begin errors++; $display("FAIL cnt_xfer%0d: got %h expected %h", k, a_vec, e); end
            @(posedge clk); #1;
        end
        checks++;
        if (a_cnt !== 16'h0100) begin errors++; $display("FAIL cnt_wrap: got %h expected 0100", a_cnt); end
        cnt_clr = 1'b1;
        sb.push_back(ex(2, 2));
        #2;
        checks++; e = sb.pop_front();
        if (a_vec !== e) begin errors++; $display("FAIL cnt_clr_push: got %h expected %h", a_vec, e); end
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        checks++;
        if (a_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_clr_zero: got %h expected 0000", a_cnt); end
        @(posedge clk); #1;
        checks++;
        if (a_cnt !== 16'h0100) begin errors++; $display("FAIL cnt_after_clr: got %h expected 0100", a_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        enable = 1'b1; empty = 4'b1011; full = 4'b0000; destino = 8'b11_10_01_00;
        sb.push_back(ex(2, 2));
        #2;
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL mid_burst_start: got %h expected %h", b_vec, e); end
        @(posedge clk); #1;
        empty = 4'b0000;
        sb.push_back(ex(2, 2));
        #2;
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL mid_burst_owner: got %h expected %h", b_vec, e); end
        reset = 1'b1;
        #1;
        sb.push_back(13'd0);
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL mid_burst_reset_drop: got %h expected %h", b_vec, e); end
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        sb.push_back(ex(0, 0));
        checks++; e = sb.pop_front();
        if (b_vec !== e) begin errors++; $display("FAIL post_reset_grant: got %h expected %h", b_vec, e); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cnt_clr = 1'b0;
        empty = 4'b1111; full = 4'b0000; destino = 8'h00;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_burst();
        test_counter_wrap();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
